// File: rtl/stopwatch_bcd4.sv
// stopwatch_bcd4: four-digit BCD stopwatch (SS.cc, 00.00-59.99) with debounced
// start/stop, lap and clear buttons, a centisecond prescaler and lap-hold display.

// Per-button front end: 2-flop synchronizer, debounce, one-cycle press pulse.
module stopwatch_btn #(
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Accept a new level only after it differs for DEBOUNCE_CYCLES straight clocks;
    // pulse only on the accepted 0->1 transition, releases are silent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], din};
            pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
                pulse <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_bcd4 #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic        btn_clr,
    output logic [15:0] bits,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);
    localparam int NUM_BTN = 3;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PW      = $clog2(DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {ST_STOPPED, ST_RUN, ST_LAP, ST_LAP_STOP} state_t;

    state_t               state, state_nxt;
    logic [NUM_BTN-1:0]   btn_raw, act;
    logic                 act_ss, act_lap, act_clr;
    logic [PW-1:0]        presc;
    logic                 tick, roll, wrap_live, lap_latch;
    logic [3:0][3:0]      live, live_inc, hold;

    assign btn_raw = {btn_clr, btn_lap, btn_ss};
    assign act_ss  = act[0];
    assign act_lap = act[1];
    assign act_clr = act[2];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        stopwatch_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .din   (btn_raw[i]),
            .pulse (act[i])
        );
    end

    assign tick = running && (presc == DIV_LAST);

    // Ripple the BCD increment across all four digits in one cycle; roll marks 59.99 -> 00.00.
    always_comb begin
        live_inc = live;
        roll     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (roll) begin
                if (live[i] == ((i == 3) ? 4'd5 : 4'd9)) begin
                    live_inc[i] = 4'd0;
                end else begin
                    live_inc[i] = live[i] + 4'd1;
                    roll        = 1'b0;
                end
            end
        end
    end

    // Next state: clear beats everything, start/stop beats lap.
    always_comb begin
        state_nxt = state;
        if (act_clr) begin
            state_nxt = ST_STOPPED;
        end else begin
            case (state)
                ST_STOPPED:  if (act_ss) state_nxt = ST_RUN;
                ST_RUN:      if (act_ss) state_nxt = ST_STOPPED;
                             else if (act_lap) state_nxt = ST_LAP;
                ST_LAP:      if (act_ss) state_nxt = ST_LAP_STOP;
                             else if (act_lap) state_nxt = ST_RUN;
                ST_LAP_STOP: if (act_ss) state_nxt = ST_LAP;
                             else if (act_lap) state_nxt = ST_STOPPED;
                default:     state_nxt = ST_STOPPED;
            endcase
        end
    end

    assign lap_latch = !act_clr && (state == ST_RUN) && !act_ss && act_lap;

    // FSM state with status flags registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_STOPPED;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            state      <= state_nxt;
            running    <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
            lap_active <= (state_nxt == ST_LAP) || (state_nxt == ST_LAP_STOP);
        end
    end

    // Time base and live count; a tick on the stop edge still lands, a tick on clear is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            live      <= '0;
            hold      <= '0;
            wrap_live <= 1'b0;
        end else if (act_clr) begin
            presc     <= '0;
            live      <= '0;
            hold      <= '0;
            wrap_live <= 1'b0;
        end else begin
            if (running) presc <= tick ? '0 : presc + 1'b1;
            if (tick) live <= live_inc;
            wrap_live <= tick && roll;
            if (lap_latch) hold <= live;
        end
    end

    // Display register; wrap is delayed alongside so it lines up with bits showing 00.00.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits <= '0;
            wrap <= 1'b0;
        end else begin
            bits <= lap_active ? hold : live;
            wrap <= wrap_live;
        end
    end
endmodule

// File: tb/tb_stopwatch_bcd4.sv
// tb_stopwatch_bcd4: per-cycle scoreboard against a behavioural stopwatch model,
// plus directed checks of the headline timing and boundary cases.
module tb_stopwatch_bcd4;
    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DB      = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
    logic [15:0] bits;
    logic        running, lap_active, wrap;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    stopwatch_bcd4 #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_ss     (btn_ss),
        .btn_lap    (btn_lap),
        .btn_clr    (btn_clr),
        .bits       (bits),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap)
    );

    typedef struct packed {
        logic [15:0] bits;
        logic        running;
        logic        lap;
        logic        wrap;
    } obs_t;

    obs_t exp_q[$];

    // Edge counter since reset release: at the negedge after edge k it reads k.
    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    // Displayed digits are simply the hundredths count written in decimal.
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Behavioural model: state 0 stopped, 1 run, 2 lap, 3 lap-stopped; time in hundredths.
    int          m_state, m_cs, m_hold, m_presc, m_cs_o, m_hold_o;
    bit          m_wrap_int, m_nw, m_tick, m_was_run, m_lap_o, m_stable;
    bit [DB+1:0] m_hist [3];
    bit          m_lvl [3];
    bit          m_act [3];
    bit          m_now [3];
    bit          m_raw [3];
    obs_t        m_out;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 0; m_cs = 0; m_hold = 0; m_presc = 0; m_wrap_int = 0;
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = '0; m_lvl[b] = 0; m_act[b] = 0;
            end
            exp_q.delete();
        end else begin
            m_raw[0] = btn_ss; m_raw[1] = btn_lap; m_raw[2] = btn_clr;
            m_now = m_act;
            // A level is accepted once the samples from 2..DB+1 edges ago all disagree with it.
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = {m_hist[b][DB:0], m_raw[b]};
                m_stable = 1;
                for (int i = 2; i <= DB + 1; i++)
                    if (m_hist[b][i] == m_lvl[b]) m_stable = 0;
                m_act[b] = 0;
                if (m_stable) begin
                    m_lvl[b] = !m_lvl[b];
                    m_act[b] = m_lvl[b];
                end
            end
            m_cs_o    = m_cs;
            m_hold_o  = m_hold;
            m_lap_o   = (m_state == 2) || (m_state == 3);
            m_was_run = (m_state == 1) || (m_state == 2);
            m_tick    = m_was_run && (m_presc == DIV - 1);
            m_nw      = 0;
            if (m_now[2]) begin
                m_state = 0; m_cs = 0; m_hold = 0; m_presc = 0;
            end else begin
                if (m_was_run) m_presc = (m_presc + 1) % DIV;
                if (m_tick) begin
                    m_nw = (m_cs == 5999);
                    m_cs = (m_cs + 1) % 6000;
                end
                case (m_state)
                    0: if (m_now[0]) m_state = 1;
                    1: if (m_now[0]) m_state = 0;
                       else if (m_now[1]) begin m_state = 2; m_hold = m_cs_o; end
                    2: if (m_now[0]) m_state = 3; else if (m_now[1]) m_state = 1;
                    default: if (m_now[0]) m_state = 2; else if (m_now[1]) m_state = 0;
                endcase
            end
            m_out.bits    = to_bcd(m_lap_o ? m_hold_o : m_cs_o);
            m_out.wrap    = m_wrap_int;
            m_wrap_int    = m_nw;
            m_out.running = (m_state == 1) || (m_state == 2);
            m_out.lap     = (m_state == 2) || (m_state == 3);
            exp_q.push_back(m_out);
        end
    end

    // Monitor: every cycle out of reset the DUT presents one observation to match.
    obs_t mon_e, mon_a;
    always @(negedge clk) begin
        if (rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {bits, running, lap_active, wrap};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d got bits=%h run=%b lap=%b wrap=%b expected bits=%h run=%b lap=%b wrap=%b",
                         cyc, mon_a.bits, mon_a.running, mon_a.lap, mon_a.wrap,
                         mon_e.bits, mon_e.running, mon_e.lap, mon_e.wrap);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_bits(input string name, input logic [15:0] v, input int bound);
        int n = 0;
        while (bits !== v && n < bound) begin @(negedge clk); n++; end
        chk(name, 32'(bits), 32'(v));
    endtask

    // Hold the selected buttons for 7 samples; returns at the negedge right after the action edge.
    task automatic press(input bit ss, input bit lap, input bit clr);
        btn_ss = ss; btn_lap = lap; btn_clr = clr;
        repeat (7) @(negedge clk);
        btn_ss = 0; btn_lap = 0; btn_clr = 0;
    endtask

    initial begin
        int n;
        logic [15:0] v;
        repeat (3) @(negedge clk);
        chk("reset_bits", 32'(bits), 32'h0);
        chk("reset_flags", {29'd0, running, lap_active, wrap}, 32'h0);
        rst = 1'b1;

        // 3-sample glitch must not start the watch
        wait_cyc(2);  btn_ss = 1;
        wait_cyc(5);  btn_ss = 0;
        wait_cyc(20);
        chk("glitch_no_start", 32'(running), 32'h0);

        // clean press held 10 cycles: running on the 7th edge after the rise
        wait_cyc(29); btn_ss = 1;
        wait_cyc(35); chk("start_edge6", 32'(running), 32'h0);
        wait_cyc(36); chk("start_edge7", 32'(running), 32'h1);
        wait_cyc(39); btn_ss = 0;

        // lap at 00.25 freezes display while live keeps counting
        wait_bits("reach_0025", 16'h0025, 400);
        press(0, 1, 0);
        repeat (20) @(negedge clk);
        chk("lap_frozen_bits", 32'(bits), 32'h0025);
        chk("lap_frozen_flag", 32'(lap_active), 32'h1);
        n = 0;
        while (m_cs != 40 && n < 300) begin @(negedge clk); n++; end
        press(0, 1, 0);
        @(negedge clk);
        chk("lap_release_bits", 32'(bits), 32'h0040);
        chk("lap_release_flag", 32'(lap_active), 32'h0);

        // pause with prescaler at 6, hold 50 cycles, then resume
        v = bits; n = 0;
        while (bits === v && n < 20) begin @(negedge clk); n++; end
        repeat (8) @(negedge clk);
        press(1, 0, 0);
        chk("pause_stopped", 32'(running), 32'h0);
        repeat (50) @(negedge clk);
        press(1, 0, 0);
        repeat (30) @(negedge clk);

        // start/stop and lap together: start/stop wins
        press(1, 1, 0);
        chk("ss_lap_running", 32'(running), 32'h0);
        chk("ss_lap_lap", 32'(lap_active), 32'h0);
        repeat (20) @(negedge clk);
        press(1, 0, 0);

        // long run: 10.00, then clear+start/stop at 12.34
        wait_bits("reach_1000", 16'h1000, 11000);
        wait_bits("reach_1234", 16'h1234, 2500);
        press(1, 0, 1);
        @(negedge clk);
        chk("clr_bits", 32'(bits), 32'h0);
        chk("clr_running", 32'(running), 32'h0);

        // full-scale roll-over
        repeat (20) @(negedge clk);
        press(1, 0, 0);
        wait_bits("reach_5999", 16'h5999, 61000);
        n = 0;
        while (bits === 16'h5999 && n < 20) begin @(negedge clk); n++; end
        chk("wrap_bits", 32'(bits), 32'h0);
        chk("wrap_pulse", 32'(wrap), 32'h1);
        @(negedge clk);
        chk("wrap_one_cycle", 32'(wrap), 32'h0);

        // randomized button traffic, including glitches and coincident presses
        for (int it = 0; it < 50; it++) begin
            btn_ss  = ($urandom_range(0, 2) == 0);
            btn_lap = ($urandom_range(0, 2) == 0);
            btn_clr = ($urandom_range(0, 9) == 0);
            repeat ($urandom_range(1, 9)) @(negedge clk);
            btn_ss = 0; btn_lap = 0; btn_clr = 0;
            repeat ($urandom_range(6, 40)) @(negedge clk);
        end

        // asynchronous reset in the middle of a run
        repeat (20) @(negedge clk);
        press(0, 0, 1);
        repeat (20) @(negedge clk);
        press(1, 0, 0);
        repeat (25) @(negedge clk);
        chk("pre_reset_running", 32'(running), 32'h1);
        #3 rst = 1'b0;
        #1;
        chk("async_reset_bits", 32'(bits), 32'h0);
        chk("async_reset_flags", {29'd0, running, lap_active, wrap}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_bits", 32'(bits), 32'h0);
        chk("post_reset_running", 32'(running), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
